// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the pipeline control FSM state and a bundle of
// the per-stage register load enables.
// Latency: n/a (types only). Backpressure: n/a.
package rv32i_types;

    // Stall/flush sequencer state: RUN while memory keeps up, MEM_WAIT while an
    // instruction or data response is still outstanding.
    typedef enum logic {
        PC_RUN,
        PC_MEM_WAIT
    } pipe_ctrl_state_t;

    // Load enables for the PC and the four inter-stage pipeline registers.
    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } pipe_en_t;

    // Nothing moves: memory stall or reset.
    localparam pipe_en_t PIPE_EN_NONE = '{
        pc: 1'b0, if_id: 1'b0, id_ex: 1'b0, ex_mem: 1'b0, mem_wb: 1'b0
    };

    // Every register advances: normal flow and branch redirects.
    localparam pipe_en_t PIPE_EN_ALL = '{
        pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1
    };

    // Load-use bubble: front end (PC, IF/ID) holds, back end drains while
    // ID/EX takes a bubble.
    localparam pipe_en_t PIPE_EN_BUBBLE = '{
        pc: 1'b0, if_id: 1'b0, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1
    };

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count visible the cycle after inc/clr. Backpressure: none; sticks at all-ones.
// Ports: clk, rst (async, active-high), inc (count this cycle), clr (zero next
// cycle), cnt (current value).
module perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: register enables, bubbles, perf counters.
// Latency: load_*/flush_* are combinational (0 cycles); stall_active and counters are registered.
// Backpressure: any outstanding imem/dmem response freezes every stage until both sides are done.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_read / imem_resp    fetch request outstanding / instruction response pulse
//   dmem_access / dmem_resp  MEM-stage request outstanding / data response pulse
//   load_use, br_taken       hazard inputs from ID/EX and EX
//   counter_clr              synchronous clear of both performance counters
//   load_*                   PC and pipeline register load enables
//   flush_if_id, flush_id_ex insert NOP/bubble into IF/ID and ID/EX
//   stall_active             FSM is in MEM_WAIT
//   stall_cycles             cycles where the pipeline did not fully advance
//   flush_count              taken-branch flush events
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_access,
    input  logic                 dmem_resp,
    input  logic                 load_use,
    input  logic                 br_taken,
    input  logic                 counter_clr,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 stall_active,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    pipe_ctrl_state_t state;

    // A response that arrives while the other side is still pending is
    // remembered here, because the response itself is only a one-cycle pulse.
    logic i_done;
    logic d_done;

    logic i_ok;
    logic d_ok;
    logic mem_ok;

    pipe_en_t en;
    logic     flush_if_id_c;
    logic     flush_id_ex_c;
    logic     stall_inc;
    logic     flush_inc;

    assign i_ok   = !imem_read   || imem_resp || i_done;
    assign d_ok   = !dmem_access || dmem_resp || d_done;
    assign mem_ok = i_ok && d_ok;

    // Hazard priority decode. A memory stall freezes everything, including a
    // pending branch, so the redirect happens exactly once when memory is
    // ready. A branch outranks load-use because the dependent instruction is
    // squashed by the flush anyway.
    always_comb begin
        en            = PIPE_EN_NONE;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (rst) begin
            // Hold every register and count nothing while in reset.
            en = PIPE_EN_NONE;
        end else if (!mem_ok) begin
            stall_inc = 1'b1;
        end else if (br_taken) begin
            en            = PIPE_EN_ALL;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
            flush_inc     = 1'b1;
        end else if (load_use) begin
            en            = PIPE_EN_BUBBLE;
            flush_id_ex_c = 1'b1;
            stall_inc     = 1'b1;
        end else begin
            en = PIPE_EN_ALL;
        end
    end

    assign load_pc     = en.pc;
    assign load_if_id  = en.if_id;
    assign load_id_ex  = en.id_ex;
    assign load_ex_mem = en.ex_mem;
    assign load_mem_wb = en.mem_wb;
    assign flush_if_id = flush_if_id_c;
    assign flush_id_ex = flush_id_ex_c;

    // Memory-wait FSM. The done flags live only for the duration of one stall:
    // they clear on the cycle the pipeline advances, so a later request never
    // sees a stale completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PC_RUN;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            stall_active <= 1'b0;
        end else if (mem_ok) begin
            state        <= PC_RUN;
            i_done       <= 1'b0;
            d_done       <= 1'b0;
            stall_active <= 1'b0;
        end else begin
            state        <= PC_MEM_WAIT;
            stall_active <= 1'b1;
            if (imem_resp) begin
                i_done <= 1'b1;
            end
            if (dmem_resp) begin
                d_done <= 1'b1;
            end
        end
    end

    perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .clr (counter_clr),
        .cnt (stall_cycles)
    );

    perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .clr (counter_clr),
        .cnt (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: memory stalls, load-use, branch flushes,
// counter clear/saturation and asynchronous reset.
// Counters are 4 bits wide here so saturation is reachable in a few cycles.
module tb_pipeline_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          imem_read;
    logic          imem_resp;
    logic          dmem_access;
    logic          dmem_resp;
    logic          load_use;
    logic          br_taken;
    logic          counter_clr;
    logic          load_pc;
    logic          load_if_id;
    logic          load_id_ex;
    logic          load_ex_mem;
    logic          load_mem_wb;
    logic          flush_if_id;
    logic          flush_id_ex;
    logic          stall_active;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    logic [6:0] outs;
    assign outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                   flush_if_id, flush_id_ex};

    localparam logic [6:0] O_STALL  = 7'b00000_00;
    localparam logic [6:0] O_RUN    = 7'b11111_00;
    localparam logic [6:0] O_BUBBLE = 7'b00111_01;
    localparam logic [6:0] O_BRANCH = 7'b11111_11;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(
        .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .dmem_access  (dmem_access),
        .dmem_resp    (dmem_resp),
        .load_use     (load_use),
        .br_taken     (br_taken),
        .counter_clr  (counter_clr),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .stall_active (stall_active),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge, then settle 1 time unit.
    // Combinational outputs then reflect this cycle; registered outputs
    // reflect the state after the previous rising edge.
    task automatic drive(input logic ir, input logic irs, input logic da, input logic drs,
                         input logic lu, input logic br, input logic clr);
        @(negedge clk);
        imem_read   = ir;
        imem_resp   = irs;
        dmem_access = da;
        dmem_resp   = drs;
        load_use    = lu;
        br_taken    = br;
        counter_clr = clr;
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        imem_read   = 1'b0;
        imem_resp   = 1'b0;
        dmem_access = 1'b0;
        dmem_resp   = 1'b0;
        load_use    = 1'b0;
        br_taken    = 1'b0;
        counter_clr = 1'b0;
        #2;
        // Idle inputs would normally advance everything; reset must hold it.
        total++;
        if (outs !== O_STALL) begin
            bad++;
            $display("FAIL reset_outs got=%b exp=%b", outs, O_STALL);
        end
        total++;
        if (stall_active !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall_active got=%b exp=0", stall_active);
        end
        total++;
        if (stall_cycles !== 4'd0 || flush_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (outs !== O_RUN) begin
            bad++;
            $display("FAIL post_reset_outs got=%b exp=%b", outs, O_RUN);
        end
    endtask

    task automatic test_no_hazard();
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            total++;
            if (outs !== O_RUN) begin
                bad++;
                $display("FAIL no_hazard_outs c=%0d got=%b exp=%b", c, outs, O_RUN);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (stall_cycles !== 4'd0) begin
            bad++;
            $display("FAIL no_hazard_stall_cycles got=%0d exp=0", stall_cycles);
        end
    endtask

    // dmem responds at cycle 2, imem at cycle 5: stalled 0..4, advance at 5.
    task automatic test_split_resp();
        for (int c = 0; c <= 5; c++) begin
            drive(1, (c == 5), 1, (c == 2), 0, 0, 0);
            total++;
            if (outs !== ((c < 5) ? O_STALL : O_RUN)) begin
                bad++;
                $display("FAIL split_outs c=%0d got=%b exp=%b", c, outs,
                         (c < 5) ? O_STALL : O_RUN);
            end
            total++;
            if (stall_active !== (c >= 1)) begin
                bad++;
                $display("FAIL split_stall_active c=%0d got=%b exp=%b", c, stall_active, (c >= 1));
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (stall_cycles !== 4'd5) begin
            bad++;
            $display("FAIL split_stall_cycles got=%0d exp=5", stall_cycles);
        end
        total++;
        if (stall_active !== 1'b0) begin
            bad++;
            $display("FAIL split_stall_active_end got=%b exp=0", stall_active);
        end
    endtask

    task automatic test_load_use();
        drive(0, 0, 0, 0, 1, 0, 0);
        total++;
        if (outs !== O_BUBBLE) begin
            bad++;
            $display("FAIL load_use_outs got=%b exp=%b", outs, O_BUBBLE);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (stall_cycles !== 4'd6) begin
            bad++;
            $display("FAIL load_use_stall_cycles got=%0d exp=6", stall_cycles);
        end
        total++;
        if (outs !== O_RUN) begin
            bad++;
            $display("FAIL load_use_after_outs got=%b exp=%b", outs, O_RUN);
        end
    endtask

    task automatic test_branch_load_use();
        drive(0, 0, 0, 0, 1, 1, 0);
        total++;
        if (outs !== O_BRANCH) begin
            bad++;
            $display("FAIL br_lu_outs got=%b exp=%b", outs, O_BRANCH);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (flush_count !== 4'd1) begin
            bad++;
            $display("FAIL br_lu_flush_count got=%0d exp=1", flush_count);
        end
        total++;
        if (stall_cycles !== 4'd6) begin
            bad++;
            $display("FAIL br_lu_stall_cycles got=%0d exp=6", stall_cycles);
        end
    endtask

    // Clear coincides with a load-use increment; clear must win.
    task automatic test_counter_clr();
        drive(0, 0, 0, 0, 1, 0, 1);
        total++;
        if (outs !== O_BUBBLE) begin
            bad++;
            $display("FAIL clr_outs got=%b exp=%b", outs, O_BUBBLE);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (stall_cycles !== 4'd0 || flush_count !== 4'd0) begin
            bad++;
            $display("FAIL clr_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
    endtask

    // Branch held while dmem is pending for 3 cycles, response on the 4th.
    task automatic test_branch_stall();
        for (int c = 0; c <= 3; c++) begin
            drive(0, 0, 1, (c == 3), 0, 1, 0);
            total++;
            if (outs !== ((c < 3) ? O_STALL : O_BRANCH)) begin
                bad++;
                $display("FAIL br_stall_outs c=%0d got=%b exp=%b", c, outs,
                         (c < 3) ? O_STALL : O_BRANCH);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (flush_count !== 4'd1) begin
            bad++;
            $display("FAIL br_stall_flush_count got=%0d exp=1", flush_count);
        end
        total++;
        if (stall_cycles !== 4'd3) begin
            bad++;
            $display("FAIL br_stall_stall_cycles got=%0d exp=3", stall_cycles);
        end
    endtask

    // 18 stalled fetch cycles into a 4-bit counter: must stick at 15.
    task automatic test_saturate();
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 18; c++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            if (c == 14) begin
                total++;
                if (stall_cycles !== 4'd14) begin
                    bad++;
                    $display("FAIL sat_mid got=%0d exp=14", stall_cycles);
                end
            end
        end
        total++;
        if (stall_cycles !== 4'd15) begin
            bad++;
            $display("FAIL sat_end got=%0d exp=15", stall_cycles);
        end
        drive(1, 1, 0, 0, 0, 0, 0);
        total++;
        if (outs !== O_RUN) begin
            bad++;
            $display("FAIL sat_release_outs got=%b exp=%b", outs, O_RUN);
        end
    endtask

    // d_done is set, then reset hits mid-stall with both responses present.
    task automatic test_reset_mid_stall();
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        total++;
        if (outs !== O_STALL || stall_active !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre got=%b/%b exp=%b/1", outs, stall_active, O_STALL);
        end
        #2;
        rst       = 1'b1;
        imem_resp = 1'b1;
        dmem_resp = 1'b1;
        #1;
        total++;
        if (outs !== O_STALL) begin
            bad++;
            $display("FAIL rst_mid_outs got=%b exp=%b", outs, O_STALL);
        end
        total++;
        if (stall_active !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_stall_active got=%b exp=0", stall_active);
        end
        total++;
        if (stall_cycles !== 4'd0 || flush_count !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        // Release with dmem re-issued and no response: a surviving d_done
        // would let the pipeline advance.
        @(negedge clk);
        rst       = 1'b0;
        imem_read = 1'b0;
        imem_resp = 1'b0;
        dmem_resp = 1'b0;
        #1;
        total++;
        if (outs !== O_STALL) begin
            bad++;
            $display("FAIL rst_mid_stale_d got=%b exp=%b", outs, O_STALL);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (outs !== O_STALL) begin
            bad++;
            $display("FAIL rst_mid_imem_stall got=%b exp=%b", outs, O_STALL);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (stall_cycles !== 4'd2) begin
            bad++;
            $display("FAIL rst_mid_stall_cycles got=%0d exp=2", stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_split_resp();
        test_load_use();
        test_branch_load_use();
        test_counter_clr();
        test_branch_stall();
        test_saturate();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline. It drives the load enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the bubble controls for IF/ID and ID/EX.
- It arbitrates between three hazard sources: outstanding instruction/data memory responses, load-use hazards, and taken-branch redirects.
- It also keeps stall and flush performance counters.

Parameters:
- CNT_WIDTH, 32, width of the stall_cycles and flush_count counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- imem_read  in  1  fetch stage has an instruction request outstanding this cycle
- imem_resp  in  1  instruction memory response valid (single-cycle pulse)
- dmem_access  in  1  MEM stage holds a load/store request
- dmem_resp  in  1  data memory response valid (single-cycle pulse)
- load_use  in  1  ID/EX holds a load whose rd (nonzero) matches an ID-stage rs1/rs2; computed externally
- br_taken  in  1  EX stage resolved a taken branch or jump (held stable while EX is stalled)
- counter_clr  in  1  synchronous clear of both counters
- load_pc  out  1  PC register enable
- load_if_id  out  1  IF/ID enable
- load_id_ex  out  1  ID/EX enable
- load_ex_mem  out  1  EX/MEM enable
- load_mem_wb  out  1  MEM/WB enable
- flush_if_id  out  1  IF/ID loads a NOP (ctrl word zero) instead of its input
- flush_id_ex  out  1  ID/EX loads a bubble (ctrl word zero)
- stall_active  out  1  FSM is in MEM_WAIT
- stall_cycles  out  CNT_WIDTH  count of cycles where the pipeline did not fully advance
- flush_count  out  CNT_WIDTH  count of flush events

Behaviour:
- State: FSM {RUN, MEM_WAIT}; sticky flags i_done and d_done; the two counters.
- Async reset: state=RUN, i_done=d_done=0, counters=0. While rst is high, all load_* and flush_* outputs are 0.
- i_ok = !imem_read | imem_resp | i_done.
- d_ok = !dmem_access | dmem_resp | d_done.
- mem_ok = i_ok & d_ok.
- mem_ok=0:
  - All five load_* = 0 and flush_* = 0. No register moves.
  - A response arriving this cycle sets its done flag (imem_resp -> i_done, dmem_resp -> d_done).
  - Next state = MEM_WAIT.
- mem_ok=1: the pipeline advances. Clear i_done and d_done; next state = RUN. Decode in priority order:
  - 1. br_taken: all loads = 1; flush_if_id = 1, flush_id_ex = 1. flush_count += 1. Branch outranks load_use, because the dependent instruction is itself squashed.
  - 2. load_use (no branch): load_pc = 0, load_if_id = 0; load_id_ex, load_ex_mem, load_mem_wb = 1; flush_id_ex = 1. Bubble inserted; latency 1 cycle per hazard.
  - 3. Otherwise: all loads = 1, flushes = 0.
- Output timing:
  - load_*/flush_* are combinational from current inputs and flags (zero-cycle latency to the pipeline registers).
  - stall_active is registered (equals state==MEM_WAIT).
- Simultaneous responses: imem_resp and dmem_resp in the same cycle while both are outstanding -> mem_ok=1 that cycle; no flags set.
- Early response: a response arriving while the other is still pending sets its flag; the stall holds until the other response arrives. A repeat pulse on an already-done side is ignored.
- Counters:
  - stall_cycles += 1 on every cycle with mem_ok=0, or with a load_use bubble (mem_ok=1, no branch).
  - Both counters saturate at all-ones.
  - counter_clr has priority over increment; cleared value is visible the next cycle.
- Reset mid-stall: flags and state drop immediately. The external requester re-issues after reset; no stale done flag survives.

Decomposition:
- Add to rv32i_types:
  - typedef enum logic {PC_RUN, PC_MEM_WAIT} pipe_ctrl_state_t
  - a pipe_en_t struct bundling the five enables
- Optional sub-module perf_counter (CNT_WIDTH, inc, clr, saturating), instantiated twice.
- The hazard priority decode stays inline.

Test Plan:
- No hazards: imem_read=1 with imem_resp=1 every cycle, dmem_access=0 -> all load_*=1 every cycle; stall_cycles stays 0.
- Split responses: imem_read=1, dmem_access=1; dmem_resp at cycle 2, imem_resp at cycle 5 -> loads=0 for cycles 0-4, d_done set from cycle 3, all loads=1 at cycle 5; stall_cycles=5, stall_active high for cycles 1-5.
- Load-use: load_use=1 for one cycle with mem_ok=1 -> load_pc=load_if_id=0, flush_id_ex=1, load_mem_wb=1; stall_cycles += 1.
- Branch plus load-use in the same cycle: br_taken=1, load_use=1 -> all loads=1, flush_if_id=flush_id_ex=1; flush_count=1; stall_cycles unchanged.
- Branch during stall: br_taken=1 held while dmem is pending for 3 cycles -> no flush until dmem_resp, then a single flush cycle; flush_count=1.
- Reset mid-stall with d_done=1: assert rst asynchronously -> outputs 0 immediately, stall_active=0, counters 0. After release with imem_read=1 and no response, the pipeline stalls again (the flag did not persist). Separately, hold counter_clr=1 for one cycle -> stall_cycles=0 the following cycle.
